// File: rtl/me_host_if_if.sv
// Host byte stream and exponentiation-core operand/result bundle for me_host_if.
// slave is the block's view; master is the host/core side.
interface me_host_if_if;
   logic         in_valid;
   logic [7:0]   in_data;
   logic         in_ready;
   logic         out_valid;
   logic [7:0]   out_data;
   logic         out_ready;
   logic [255:0] N_o;
   logic [255:0] M_o;
   logic [255:0] d_o;
   logic         start_o;
   logic         ready_i;
   logic [255:0] S_i;
   logic         busy;

   modport slave (
      input  in_valid, in_data, out_ready, ready_i, S_i,
      output in_ready, out_valid, out_data, N_o, M_o, d_o, start_o, busy
   );

   modport master (
      output in_valid, in_data, out_ready, ready_i, S_i,
      input  in_ready, out_valid, out_data, N_o, M_o, d_o, start_o, busy
   );
endinterface

// File: rtl/me_host_if.sv
// Loads N, M, d as 96 host bytes, pulses the core, returns S as 32 bytes.
// Unbounded latency (waits on core); in_ready only in LOAD; out_valid held through SEND stalls.
module me_host_if #(
   parameter int OP_BYTES = 32
) (
   input  logic         clk,
   input  logic         reset,
   me_host_if_if.slave  bus
);
   localparam int OP_W  = OP_BYTES * 8;
   localparam int BUF_W = 3 * OP_W;

   typedef enum logic [2:0] {
      LOAD, START, WAIT_LOW, WAIT_HIGH, CAPTURE, SEND
   } state_t;

   state_t             state, state_nxt;
   logic [BUF_W-1:0]   op_buf;
   logic [OP_W-1:0]    result;
   logic [6:0]         cnt;
   logic               in_xfer, out_xfer, last_in, last_out;

   assign in_xfer  = bus.in_valid  && (state == LOAD);
   assign out_xfer = bus.out_ready && (state == SEND);
   assign last_in  = (cnt == 7'(3 * OP_BYTES - 1));
   assign last_out = (cnt == 7'(OP_BYTES - 1));

   // Operands are read straight from the shift buffer; it only moves in LOAD.
   assign bus.N_o = op_buf[BUF_W-1 -: OP_W];
   assign bus.M_o = op_buf[2*OP_W-1 -: OP_W];
   assign bus.d_o = op_buf[OP_W-1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= LOAD;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_data  = 8'h00;
      bus.start_o   = 1'b0;
      bus.busy      = 1'b1;
      case (state)
         LOAD: begin
            bus.in_ready = 1'b1;
            bus.busy     = 1'b0;
            if (in_xfer && last_in) state_nxt = START;
         end
         START: begin
            bus.start_o = 1'b1;
            state_nxt   = WAIT_LOW;
         end
         // Core idles with ready high; wait for it to drop before looking for completion.
         WAIT_LOW:  if (!bus.ready_i) state_nxt = WAIT_HIGH;
         WAIT_HIGH: if (bus.ready_i)  state_nxt = CAPTURE;
         CAPTURE:   state_nxt = SEND;
         SEND: begin
            bus.out_valid = 1'b1;
            bus.out_data  = result[OP_W-1 -: 8];
            if (out_xfer && last_out) state_nxt = LOAD;
         end
         default:   state_nxt = LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_buf <= '0;
         result <= '0;
         cnt    <= '0;
      end else begin
         case (state)
            LOAD: begin
               if (in_xfer) begin
                  op_buf <= {op_buf[BUF_W-9:0], bus.in_data};
                  cnt    <= last_in ? 7'd0 : cnt + 7'd1;
               end
            end
            // S_i lags ready by one cycle, so it is sampled here rather than in WAIT_HIGH.
            CAPTURE: begin
               result <= bus.S_i;
               cnt    <= 7'd0;
            end
            SEND: begin
               if (out_xfer) begin
                  result <= {result[OP_W-9:0], 8'h00};
                  cnt    <= last_out ? 7'd0 : cnt + 7'd1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
